riscv_alu: RTL and testbench

//  - RV32I integer ALU for the execute stage: one opcode selects one of the base integer operations on two 32-bit operands.
//  - Result is registered, so alu_p_o is valid one clock after the operands and opcode are presented.
//  - Consumers are writeback and branch/address logic; no handshake, one new operation per cycle.

---
 rtl/riscv_alu_pkg.sv | 35 +++
 rtl/riscv_alu_shifter.sv | 30 +++
 rtl/riscv_alu.sv | 69 ++++++
 tb/tb_riscv_alu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg
// Shared definitions for the RV32I execute-stage ALU: operand width and the
// 4-bit opcode encoding used by the decoder, the ALU and its testbench.
// Optional feature macro: RISCV_ALU_MUL_EN (enables opcode 4'd11 = MUL low word).
package riscv_alu_pkg;

    localparam int XLEN = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_MUL   = 4'd11
    } alu_op_e;

    // Signed less-than built from the unsigned compare: when the sign bits
    // differ the negative operand is smaller, otherwise unsigned order holds.
    function automatic logic slt_signed(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        if (a[XLEN-1] != b[XLEN-1])
            return a[XLEN-1];
        else
            return (a < b);
    endfunction

endpackage

// File: rtl/riscv_alu_shifter.sv
// riscv_alu_shifter
// Combinational barrel shifter covering SLL, SRL and SRA.
// Ports:
//   data   in  32  value to shift
//   shamt  in  5   shift amount (0..31)
//   dir    in  1   0 = left, 1 = right
//   arith  in  1   right shifts only: 1 = sign fill, 0 = zero fill
//   result out 32  shifted value
module riscv_alu_shifter
    import riscv_alu_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] shl;
    logic [XLEN-1:0] shr;

    always_comb begin
        shl = data << shamt;
        // Arithmetic right shift: extend by one bit carrying the fill value,
        // so one shifter serves both logical and arithmetic cases.
        shr = XLEN'($signed({arith & data[XLEN-1], data}) >>> shamt);
        result = dir ? shr : shl;
    end

endmodule

// File: rtl/riscv_alu.sv
// riscv_alu
// RV32I integer ALU for the execute stage. One opcode selects one base integer
// operation; the result is registered (1-cycle latency, one op per cycle).
// Optional feature macro: RISCV_ALU_MUL_EN -- opcode 4'd11 returns the low
// 32 bits of A*B; when undefined no multiplier exists and 4'd11 yields 0.
// Ports:
//   clk       in  1   rising-edge clock
//   rstb      in  1   asynchronous active-low reset, clears alu_p_o
//   alu_op_i  in  4   operation select
//   alu_a_i   in  32  operand A (rs1 / PC)
//   alu_b_i   in  32  operand B (rs2 / immediate)
//   alu_p_o   out 32  registered result
module riscv_alu
    import riscv_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rstb,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] alu_a_i,
    input  logic [XLEN-1:0] alu_b_i,
    output logic [XLEN-1:0] alu_p_o
);

    logic [XLEN-1:0] shift_result;
    logic            shift_dir;
    logic            shift_arith;
    logic [XLEN-1:0] result_next;

    assign shift_dir   = (alu_op_i == ALU_SRL) || (alu_op_i == ALU_SRA);
    assign shift_arith = (alu_op_i == ALU_SRA);

    riscv_alu_shifter u_shifter (
        .data   (alu_a_i),
        .shamt  (alu_b_i[SHAMT_W-1:0]),
        .dir    (shift_dir),
        .arith  (shift_arith),
        .result (shift_result)
    );

    always_comb begin
        result_next = '0;
        case (alu_op_i)
            ALU_ADD:   result_next = alu_a_i + alu_b_i;
            ALU_SUB:   result_next = alu_a_i - alu_b_i;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   result_next = shift_result;
            ALU_SLT:   result_next = {{(XLEN-1){1'b0}}, slt_signed(alu_a_i, alu_b_i)};
            ALU_SLTU:  result_next = {{(XLEN-1){1'b0}}, (alu_a_i < alu_b_i)};
            ALU_XOR:   result_next = alu_a_i ^ alu_b_i;
            ALU_OR:    result_next = alu_a_i | alu_b_i;
            ALU_AND:   result_next = alu_a_i & alu_b_i;
            ALU_PASSB: result_next = alu_b_i;
`ifdef RISCV_ALU_MUL_EN
            // Low word of the product is identical for signed and unsigned.
            ALU_MUL:   result_next = alu_a_i * alu_b_i;
`endif
            default:   result_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            alu_p_o <= '0;
        else
            alu_p_o <= result_next;
    end

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu
// Self-checking bench for riscv_alu: directed literal cases plus a randomized
// stream compared every cycle against a behavioural model.
// Honours RISCV_ALU_MUL_EN the same way as the design.
module tb_riscv_alu;

    logic        clk;
    logic        rstb;
    logic [3:0]  alu_op_i;
    logic [31:0] alu_a_i;
    logic [31:0] alu_b_i;
    logic [31:0] alu_p_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic        chk_en = 1'b1;
    logic [31:0] exp_val = 32'h0;

    riscv_alu dut (
        .clk      (clk),
        .rstb     (rstb),
        .alu_op_i (alu_op_i),
        .alu_a_i  (alu_a_i),
        .alu_b_i  (alu_b_i),
        .alu_p_o  (alu_p_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: ALU result computed from the operation's arithmetic meaning.
    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * (32'd1 << sh);
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a / (32'd1 << sh);
            4'd7:  begin
                // Floor division by 2^sh equals an arithmetic right shift.
                longint q;
                q = sa / (longint'(1) << sh);
                if ((sa < 0) && (q * (longint'(1) << sh) != sa))
                    q = q - 1;
                return q[31:0];
            end
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
`ifdef RISCV_ALU_MUL_EN
            4'd11: begin
                longint unsigned p;
                p = longint'(a) * longint'(b);
                return p[31:0];
            end
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Expected output register: cleared by reset, otherwise the model of the
    // inputs sampled at the edge.
    always @(posedge clk or negedge rstb) begin
        if (!rstb)
            exp_val <= 32'h0;
        else
            exp_val <= model(alu_op_i, alu_a_i, alu_b_i);
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle_compare", alu_p_o, exp_val);
    end

    // Apply on a falling edge, then check the literal one edge later.
    task automatic lit(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want);
        @(negedge clk);
        alu_op_i = op;
        alu_a_i  = a;
        alu_b_i  = b;
        @(posedge clk);
        #1;
        check(name, alu_p_o, want);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rstb     = 1'b0;
        alu_op_i = 4'd0;
        alu_a_i  = 32'h0;
        alu_b_i  = 32'h0;

        // Reset held 20 ns with clock running.
        #20;
        check("reset_value", alu_p_o, 32'h0);
        rstb = 1'b1;
        #3;
        check("post_release_zero", alu_p_o, 32'h0);

        lit("slt_eq_zero",   4'd3, 32'h0,         32'h0, 32'h0);
        lit("slt_neg1_lt1",  4'd3, 32'hFFFF_FFFF, 32'h1, 32'h1);
        lit("sltu_max_lt1",  4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0);
        lit("slt_minint",    4'd3, 32'h8000_0000, 32'h0, 32'h1);
        lit("sltu_minint",   4'd4, 32'h8000_0000, 32'h0, 32'h0);
        lit("sltu_eq",       4'd4, 32'h1234,      32'h1234, 32'h0);
        lit("add_2020",      4'd0, 32'd2020, 32'd2021, 32'd4041);
        lit("sub_2020",      4'd1, 32'd2020, 32'd2021, 32'hFFFF_FFFF);
        lit("and_2020",      4'd9, 32'd2020, 32'd2021, 32'd2020);
        lit("or_2020",       4'd8, 32'd2020, 32'd2021, 32'd2021);
        lit("xor_2020",      4'd5, 32'd2020, 32'd2021, 32'h1);
        lit("sll_1",         4'd2, 32'h8000_0001, 32'h21, 32'h0000_0002);
        lit("srl_1",         4'd6, 32'h8000_0001, 32'h21, 32'h4000_0000);
        lit("sra_1",         4'd7, 32'h8000_0001, 32'h21, 32'hC000_0000);
        lit("sra_shamt0",    4'd7, 32'h8000_0001, 32'h20, 32'h8000_0001);
        lit("sra_31",        4'd7, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF);
        lit("passb",         4'd10, 32'h1111_1111, 32'hABCD_E000, 32'hABCD_E000);
        lit("add_wrap",      4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        lit("undef_op15",    4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        lit("undef_op12",    4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
`ifdef RISCV_ALU_MUL_EN
        lit("mul_neg",       4'd11, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        lit("op11_undef",    4'd11, 32'h3, 32'hFFFF_FFFF, 32'h0);
`endif

        // Random back-to-back stream, every cycle a new operation.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            alu_op_i = 4'($urandom_range(0, 15));
            alu_a_i  = rand_operand();
            alu_b_i  = ($urandom_range(0, 5) == 0) ? alu_a_i : rand_operand();
        end

        // Async reset between edges while ADD is producing a nonzero result.
        @(negedge clk);
        alu_op_i = 4'd0;
        alu_a_i  = 32'd5;
        alu_b_i  = 32'd7;
        @(posedge clk);
        #1;
        check("pre_reset_add", alu_p_o, 32'd12);
        #1;
        rstb = 1'b0;
        #1;
        check("async_clear", alu_p_o, 32'h0);
        @(posedge clk);
        #1;
        check("held_in_reset", alu_p_o, 32'h0);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("resume_after_reset", alu_p_o, 32'd12);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
